// File: rtl/capture_pkg.sv
// Shared types and widths for the frame-window capture path.
package capture_pkg;

    localparam int PIX_W        = 2;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/capture_packer.sv
// Captures one rectangular window of a pixel raster, packs 16 2-bit pixels per 32-bit word,
// and streams the words out through a small FIFO.
module capture_packer
    import capture_pkg::*;
#(
    parameter int COL_START  = 100,
    parameter int ROW_START  = 0,
    parameter int WIN_W      = 256,
    parameter int WIN_H      = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Arm,
    input  logic              i_Pix_Valid,
    input  logic [9:0]        i_Row,
    input  logic [9:0]        i_Col,
    input  logic [PIX_W-1:0]  i_Pixel,
    output logic [WORD_W-1:0] o_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Overflow,
    output state_t            o_State
);

    localparam int NUM_WORDS = (WIN_W * WIN_H) / PIX_PER_WORD;
    localparam int WC_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [10:0]     ROW_LO    = 11'(ROW_START);
    localparam logic [10:0]     ROW_HI    = 11'(ROW_START + WIN_H);
    localparam logic [10:0]     COL_LO    = 11'(COL_START);
    localparam logic [10:0]     COL_HI    = 11'(COL_START + WIN_W);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
    localparam logic [3:0]      LAST_PIX  = 4'(PIX_PER_WORD - 1);

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   shift_reg;
    logic [3:0]          pix_cnt;
    logic [WC_W-1:0]     word_cnt;
    logic                done_q;
    logic                overflow_q;

    logic                in_window;
    logic                sof_hit;
    logic                arm_idle;
    logic                take;
    logic                word_push;
    logic                last_word;
    logic [WORD_W-1:0]   word;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;

    assign in_window = i_Pix_Valid
                    && ({1'b0, i_Row} >= ROW_LO) && ({1'b0, i_Row} < ROW_HI)
                    && ({1'b0, i_Col} >= COL_LO) && ({1'b0, i_Col} < COL_HI);
    assign sof_hit   = in_window && (i_Row == 10'(ROW_START)) && (i_Col == 10'(COL_START));
    assign arm_idle  = i_Arm && (state == IDLE);
    assign take      = ((state == WAIT_SOF) && sof_hit) || ((state == CAPTURE) && in_window);
    assign word      = {shift_reg[WORD_W-PIX_W-1:0], i_Pixel};
    assign word_push = take && (pix_cnt == LAST_PIX);
    assign last_word = word_push && (word_cnt == LAST_WORD);

    // Stream handshake: o_Valid means o_Data holds the head word; a word transfers on
    // every rising edge where o_Valid && i_Ready, and o_Data/o_Valid hold until then.
    assign pop = o_Valid && i_Ready;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_Arm)     state_next = WAIT_SOF;
            WAIT_SOF: if (sof_hit)   state_next = CAPTURE;
            CAPTURE:  if (last_word) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        o_Busy     = (state != IDLE);
        o_Done     = done_q;
        o_Overflow = overflow_q;
        o_State    = state;
    end

    // Word count advances even on a dropped word so the frame length is preserved.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            shift_reg  <= '0;
            pix_cnt    <= '0;
            word_cnt   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= last_word;
            if (arm_idle) begin
                pix_cnt    <= '0;
                word_cnt   <= '0;
                overflow_q <= 1'b0;
            end
            if (take) begin
                shift_reg <= word;
                pix_cnt   <= pix_cnt + 4'd1;
            end
            if (word_push) begin
                word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
                if (fifo_full && !pop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_Clk),
        .rst_n     (i_Rst_n),
        .clear     (arm_idle),
        .push      (word_push),
        .push_data (word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (o_Data)
    );

    assign o_Valid = !fifo_empty;

endmodule
